// File: rtl/fwd_tracker_pkg.sv
// Shared encodings, widths and stage-compare helper for the forwarding tracker.
package fwd_tracker_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    localparam logic [1:0]       FWD_NONE = 2'b00;
    localparam logic [1:0]       FWD_WB   = 2'b01;
    localparam logic [1:0]       FWD_MEM  = 2'b10;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // A stage can supply a forward only if it writes a real (non-zero) register.
    function automatic logic stage_hits(input logic [REG_W-1:0] wreg,
                                        input logic             regwrite,
                                        input logic [REG_W-1:0] src);
        return regwrite && (wreg != REG_ZERO) && (wreg == src);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: MEM result is newer than WB, so it wins.
module fwd_sel
    import fwd_tracker_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_wreg,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_wreg,
    input  logic             wb_regwrite,
    output logic [1:0]       sel
);

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = FWD_NONE;
        if (stage_hits(mem_wreg, mem_regwrite, src)) begin
            sel = FWD_MEM;
        end else if (stage_hits(wb_wreg, wb_regwrite, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_tracker.sv
// Tracks EX/MEM and MEM/WB destinations, drives ALU forwarding selects,
// detects load-use hazards and counts the resulting stall cycles.
module fwd_tracker
    import fwd_tracker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             hold,
    input  logic             flush,
    output logic [REG_W-1:0] mem_wreg,
    output logic             mem_regwrite,
    output logic [REG_W-1:0] wb_wreg,
    output logic             wb_regwrite,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             load_use,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign load_use = ex_memread && ex_regwrite && (ex_wreg != REG_ZERO) &&
                      ((ex_wreg == id_rs) || (ex_wreg == id_rt));

    // Priority: rst, then hold (freezes everything, flush ignored), then flush.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so wb_* samples the old mem_* on the same edge.
        if (rst) begin
            mem_wreg     <= REG_ZERO;
            mem_regwrite <= 1'b0;
            wb_wreg      <= REG_ZERO;
            wb_regwrite  <= 1'b0;
            stall_cnt    <= '0;
        end else if (!hold) begin
            if (flush) begin
                mem_wreg     <= REG_ZERO;
                mem_regwrite <= 1'b0;
            end else begin
                mem_wreg     <= ex_wreg;
                mem_regwrite <= ex_regwrite;
            end
            wb_wreg     <= mem_wreg;
            wb_regwrite <= mem_regwrite;
            if (load_use && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    fwd_sel u_fwd_a (
        .src          (ex_rs),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .wb_wreg      (wb_wreg),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src          (ex_rt),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .wb_wreg      (wb_wreg),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b)
    );

endmodule

// File: tb/tb_fwd_tracker.sv
// Self-checking bench for fwd_tracker: directed vector table, multi-cycle
// sequences, randomized traffic against a queue-based model, saturation.
module tb_fwd_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wreg, ex_rs, ex_rt, id_rs, id_rt;
    logic        ex_regwrite, ex_memread, hold, flush;
    logic [4:0]  mem_wreg, wb_wreg;
    logic        mem_regwrite, wb_regwrite, load_use;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .ex_wreg      (ex_wreg),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .hold         (hold),
        .flush        (flush),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .wb_wreg      (wb_wreg),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .load_use     (load_use),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit h, input bit f, input int wreg, input bit rw,
                         input bit mr, input int rs, input int rt, input int irs, input int irt);
        rst = r; hold = h; flush = f;
        ex_wreg = 5'(wreg); ex_regwrite = rw; ex_memread = mr;
        ex_rs = 5'(rs); ex_rt = 5'(rt); id_rs = 5'(irs); id_rt = 5'(irt);
    endtask

    // Reference model: the pipeline is the list of destinations that entered
    // on advancing edges; newest entry is the MEM stage, the one before is WB.
    typedef struct { int wreg; bit rw; } dst_t;
    dst_t hist[$];
    int   m_cnt;

    function automatic dst_t stage_at(input int age);
        dst_t none = '{0, 1'b0};
        if (hist.size() > age) return hist[hist.size() - 1 - age];
        return none;
    endfunction

    function automatic int fwd_model(input int src);
        for (int age = 0; age < 2; age++) begin
            dst_t d = stage_at(age);
            if (d.rw && d.wreg != 0 && d.wreg == src) return (age == 0) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic bit lu_model(input int wreg, input bit rw, input bit mr, input int irs, input int irt);
        return mr && rw && wreg != 0 && (wreg == irs || wreg == irt);
    endfunction

    task automatic model_edge(input bit r, input bit h, input bit f, input int wreg, input bit rw, input bit lu);
        dst_t d;
        if (r) begin
            hist.delete();
            m_cnt = 0;
        end else if (!h) begin
            if (lu && m_cnt < 65535) m_cnt++;
            d = f ? '{0, 1'b0} : '{wreg, rw};
            hist.push_back(d);
            if (hist.size() > 2) void'(hist.pop_front());
        end
    endtask

    typedef struct {
        bit hold, flush; int wreg; bit rw, mr; int rs, rt, irs, irt;
        int e_fa, e_fb; bit e_lu; int e_mw; bit e_mrw; int e_ww; bit e_wrw; int e_cnt;
    } vec_t;
    vec_t vecs[13];

    initial begin
        int v_rs, v_rt, v_lu;
        dst_t mem_s, wb_s;

        // hold flush wreg rw mr rs rt irs irt | fa fb lu mw mrw ww wrw cnt
        vecs[0]  = '{0,0, 8,1,0, 0,0,0,0,  0,0,0, 8,1, 0,0, 0};
        vecs[1]  = '{0,0, 3,0,0, 8,0,0,0,  2,0,0, 3,0, 8,1, 0};
        vecs[2]  = '{0,0, 0,0,0, 8,0,0,0,  1,0,0, 0,0, 3,0, 0};
        vecs[3]  = '{0,0, 9,1,0, 0,0,0,0,  0,0,0, 9,1, 0,0, 0};
        vecs[4]  = '{0,0, 9,1,0, 0,9,0,0,  0,2,0, 9,1, 9,1, 0};
        vecs[5]  = '{0,0, 0,0,0, 9,9,0,0,  2,2,0, 0,0, 9,1, 0};
        vecs[6]  = '{0,0, 0,1,0, 0,9,0,0,  0,1,0, 0,1, 0,0, 0};
        vecs[7]  = '{0,0, 0,0,1, 0,0,0,0,  0,0,0, 0,0, 0,1, 0};
        vecs[8]  = '{0,0, 5,1,1, 0,0,0,5,  0,0,1, 5,1, 0,0, 1};
        vecs[9]  = '{1,1, 7,1,0, 5,0,0,0,  2,0,0, 5,1, 0,0, 1};
        vecs[10] = '{1,0, 5,1,1, 0,0,5,0,  0,0,1, 5,1, 0,0, 1};
        vecs[11] = '{0,1, 7,1,1, 0,0,7,0,  0,0,1, 0,0, 5,1, 2};
        vecs[12] = '{0,0, 0,0,0, 0,5,0,0,  0,1,0, 0,0, 0,0, 2};

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset mem_wreg", mem_wreg, 0);
        check("reset mem_regwrite", mem_regwrite, 0);
        check("reset wb_wreg", wb_wreg, 0);
        check("reset wb_regwrite", wb_regwrite, 0);
        check("reset stall_cnt", stall_cnt, 0);
        check("reset fwd_a", fwd_a, 0);
        check("reset fwd_b", fwd_b, 0);
        check("reset load_use", load_use, 0);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            drive(0, vecs[i].hold, vecs[i].flush, vecs[i].wreg, vecs[i].rw, vecs[i].mr,
                  vecs[i].rs, vecs[i].rt, vecs[i].irs, vecs[i].irt);
            @(negedge clk);
            check($sformatf("vec%0d fwd_a", i), fwd_a, vecs[i].e_fa);
            check($sformatf("vec%0d fwd_b", i), fwd_b, vecs[i].e_fb);
            check($sformatf("vec%0d load_use", i), load_use, vecs[i].e_lu);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d mem_wreg", i), mem_wreg, vecs[i].e_mw);
            check($sformatf("vec%0d mem_regwrite", i), mem_regwrite, vecs[i].e_mrw);
            check($sformatf("vec%0d wb_wreg", i), wb_wreg, vecs[i].e_ww);
            check($sformatf("vec%0d wb_regwrite", i), wb_regwrite, vecs[i].e_wrw);
            check($sformatf("vec%0d stall_cnt", i), stall_cnt, vecs[i].e_cnt);
        end

        // Mid-stream reset while hold is high discards in-flight destinations
        drive(0, 0, 0, 12, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 13, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("pre-reset mem_wreg", mem_wreg, 13);
        check("pre-reset wb_wreg", wb_wreg, 12);
        drive(1, 1, 1, 14, 1, 0, 12, 13, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 12, 13, 0, 0);
        #1;
        check("midreset mem_regwrite", mem_regwrite, 0);
        check("midreset wb_regwrite", wb_regwrite, 0);
        check("midreset mem_wreg", mem_wreg, 0);
        check("midreset stall_cnt", stall_cnt, 0);
        check("midreset fwd_a", fwd_a, 0);
        check("midreset fwd_b", fwd_b, 0);

        // Randomized traffic against the model (state is known-reset here)
        hist.delete();
        m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            v_rs = fwd_model(ex_rs);
            v_rt = fwd_model(ex_rt);
            v_lu = lu_model(ex_wreg, ex_regwrite, ex_memread, id_rs, id_rt);
            @(negedge clk);
            check("rand fwd_a", fwd_a, v_rs);
            check("rand fwd_b", fwd_b, v_rt);
            check("rand load_use", load_use, v_lu);
            @(posedge clk);
            model_edge(rst, hold, flush, ex_wreg, ex_regwrite, v_lu[0]);
            #1;
            mem_s = stage_at(0);
            wb_s  = stage_at(1);
            check("rand mem_wreg", mem_wreg, mem_s.wreg);
            check("rand mem_regwrite", mem_regwrite, mem_s.rw);
            check("rand wb_wreg", wb_wreg, wb_s.wreg);
            check("rand wb_regwrite", wb_regwrite, wb_s.rw);
            check("rand stall_cnt", stall_cnt, m_cnt);
        end

        // Saturation: reset, drive the counter to FFFE, then 3 more stalls
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 5, 1, 1, 0, 0, 5, 0);
        repeat (65534) @(posedge clk);
        #1;
        check("preload stall_cnt", stall_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("sat stall_cnt %0d", k), stall_cnt, 16'hFFFF);
        end
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("final reset stall_cnt", stall_cnt, 0);
        check("final reset mem_wreg", mem_wreg, 0);
        check("final reset mem_regwrite", mem_regwrite, 0);
        check("final reset wb_wreg", wb_wreg, 0);
        check("final reset wb_regwrite", wb_regwrite, 0);
        check("final reset fwd_a", fwd_a, 0);
        check("final reset fwd_b", fwd_b, 0);
        check("final reset load_use", load_use, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
